// File: rtl/registers_dump_sequencer.sv
// Debug dump sequencer: borrows bank read port A, walks every register and streams each
// word out little-endian as bytes. Optional macro REGISTERS_DUMP_SKIP_ZERO_EN starts at r1.
module registers_dump_sequencer #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int BYTE_SIZE           = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_start,
    input  logic                                   i_abort,
    input  logic [REGISTERS_SIZE-1:0]              i_reg_data,
    input  logic                                   i_data_ready,
    output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_addr,
    output logic                                   o_port_sel,
    output logic [BYTE_SIZE-1:0]                   o_data,
    output logic                                   o_data_valid,
    output logic                                   o_busy,
    output logic                                   o_done
);
    localparam int AW  = $clog2(REGISTERS_BANK_SIZE);
    localparam int BPR = REGISTERS_SIZE / BYTE_SIZE;
    localparam int BCW = $clog2(BPR + 1);

    localparam logic [AW-1:0]  LAST_ADDR = AW'(REGISTERS_BANK_SIZE - 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPR - 1);
`ifdef REGISTERS_DUMP_SKIP_ZERO_EN
    localparam logic [AW-1:0]  FIRST_ADDR = AW'(1);
`else
    localparam logic [AW-1:0]  FIRST_ADDR = '0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, SEND, NEXT, DONE} state_t;

    state_t                    state, state_next;
    logic [AW-1:0]             addr_cnt;
    logic [BCW-1:0]            byte_cnt;
    logic [REGISTERS_SIZE-1:0] shift_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Abort overrides every transition; in IDLE it also masks a coincident start.
    always_comb begin
        state_next = state;
        if (i_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (i_start) state_next = LOAD;
                LOAD: state_next = SEND;
                SEND: if (i_data_ready && byte_cnt == LAST_BYTE) state_next = NEXT;
                NEXT: state_next = (addr_cnt == LAST_ADDR) ? DONE : LOAD;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Address counter parks at zero whenever the sequencer is (or is about to be) idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_cnt  <= '0;
            byte_cnt  <= '0;
            shift_reg <= '0;
        end else if (state_next == IDLE) begin
            addr_cnt <= '0;
        end else begin
            case (state)
                IDLE: addr_cnt <= FIRST_ADDR;
                LOAD: begin
                    shift_reg <= i_reg_data;
                    byte_cnt  <= '0;
                end
                SEND: if (i_data_ready) begin
                    shift_reg <= shift_reg >> BYTE_SIZE;
                    byte_cnt  <= byte_cnt + 1'b1;
                end
                NEXT: addr_cnt <= addr_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_addr       = addr_cnt;
        o_port_sel   = (state == LOAD) || (state == SEND) || (state == NEXT);
        o_data_valid = (state == SEND);
        o_data       = (state == SEND) ? shift_reg[BYTE_SIZE-1:0] : '0;
        o_busy       = (state != IDLE);
        o_done       = (state == DONE);
    end

endmodule

// File: tb/tb_registers_dump_sequencer.sv
// Directed bench for registers_dump_sequencer: full dumps, backpressure, abort, reset,
// busy-start and mid-dump register write.
module tb_registers_dump_sequencer;
`ifdef REGISTERS_DUMP_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NREGS    = 32 - FIRST;
    localparam int NBYTES   = NREGS * 4;
    localparam int DONE_CYC = 1 + NREGS * 6 + 1;

    logic        clk, reset, start, abort, ready;
    logic [31:0] reg_data;
    logic [4:0]  addr;
    logic        port_sel, data_valid, busy, done;
    logic [7:0]  data;

    logic [31:0] bank [32];
    logic [7:0]  got  [256];
    int tests, failed;

    assign reg_data = bank[addr];

    registers_dump_sequencer #(
        .REGISTERS_BANK_SIZE(32),
        .REGISTERS_SIZE(32),
        .BYTE_SIZE(8)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort),
        .i_reg_data(reg_data), .i_data_ready(ready),
        .o_addr(addr), .o_port_sel(port_sel), .o_data(data),
        .o_data_valid(data_valid), .o_busy(busy), .o_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_addr"}, 32'(addr), 32'h0);
        check({tag, "_port_sel"}, 32'(port_sel), 32'h0);
        check({tag, "_data"}, 32'(data), 32'h0);
        check({tag, "_valid"}, 32'(data_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
    endtask

    // Start a dump with start asserted in cycle 1 and collect accepted bytes into got[].
    task automatic run_dump(input bit toggle, input bit restart_r3, input bit write_r7,
                            output int done_cyc, output int nbytes,
                            output int first_valid, output int unstable);
        int cyc;
        bit prev_stall;
        logic [7:0] prev_data;
        done_cyc = 0; nbytes = 0; first_valid = 0; unstable = 0;
        prev_stall = 1'b0; prev_data = '0;
        start = 1'b1; ready = 1'b1; cyc = 1;
        for (int k = 0; k < 2000 && done_cyc == 0; k++) begin
            tick();
            cyc++;
            start = 1'b0;
            if (prev_stall && (!data_valid || data !== prev_data)) unstable++;
            if (done) done_cyc = cyc;
            if (data_valid && first_valid == 0) first_valid = cyc;
            if (restart_r3 && addr == 5'd3 && data_valid) start = 1'b1;
            if (write_r7 && addr == 5'd2) bank[7] = 32'hDEADBEEF;
            ready = toggle ? ~ready : 1'b1;
            if (data_valid && ready) begin
                if (nbytes < 256) got[nbytes] = data;
                nbytes++;
            end
            prev_stall = data_valid && !ready;
            prev_data  = data;
        end
        start = 1'b0;
        ready = 1'b1;
    endtask

    task automatic check_bytes(input string tag);
        logic [31:0] w;
        for (int i = 0; i < NBYTES; i++) begin
            w = bank[FIRST + i / 4] >> (8 * (i % 4));
            check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(w[7:0]));
        end
    endtask

    initial begin
        int dc, nb, fv, us, seen_done, nbx;
        bit hit;
        tests = 0; failed = 0;
        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        bank[0] = 32'h0;
        for (int k = 1; k < 32; k++) bank[k] = 32'h11223300 + 32'(k);

        tick(); tick(); tick();
        check_idle("reset");
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // Full dump with ready held high
        run_dump(1'b0, 1'b0, 1'b0, dc, nb, fv, us);
        check("done_cycle", 32'(dc), 32'(DONE_CYC));
        check("byte_count", 32'(nb), 32'(NBYTES));
        check("first_valid_cycle", 32'(fv), 32'd3);
`ifdef REGISTERS_DUMP_SKIP_ZERO_EN
        check("r1_b0", 32'(got[0]), 32'h01);
        check("r1_b1", 32'(got[1]), 32'h33);
        check("r1_b2", 32'(got[2]), 32'h22);
        check("r1_b3", 32'(got[3]), 32'h11);
`else
        check("r0_b0", 32'(got[0]), 32'h00);
        check("r0_b3", 32'(got[3]), 32'h00);
        check("r1_b0", 32'(got[4]), 32'h01);
        check("r1_b1", 32'(got[5]), 32'h33);
        check("r1_b2", 32'(got[6]), 32'h22);
        check("r1_b3", 32'(got[7]), 32'h11);
`endif
        check("r31_b0", 32'(got[NBYTES-4]), 32'h1F);
        check_bytes("ready1");
        tick();
        check_idle("after_done");

        // Backpressure: ready toggles every cycle
        run_dump(1'b1, 1'b0, 1'b0, dc, nb, fv, us);
        check("toggle_done_seen", 32'(dc != 0), 32'h1);
        check("toggle_byte_count", 32'(nb), 32'(NBYTES));
        check("toggle_stable", 32'(us), 32'h0);
        check_bytes("toggle");
        tick();

        // Start while busy is ignored
        run_dump(1'b0, 1'b1, 1'b0, dc, nb, fv, us);
        check("busy_start_done_cycle", 32'(dc), 32'(DONE_CYC));
        check("busy_start_byte_count", 32'(nb), 32'(NBYTES));
        tick();

        // Abort while byte 2 of r5 is presented, with the handshake in flight
        start = 1'b1; ready = 1'b1; nbx = 0; hit = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (data_valid && nbx == (5 - FIRST) * 4 + 2) begin
                hit = 1'b1;
                break;
            end
            if (data_valid && ready) nbx++;
            tick();
        end
        check("abort_reached_r5_b2", 32'(hit), 32'h1);
        check("abort_r5_addr", 32'(addr), 32'd5);
        check("abort_r5_b2_data", 32'(data), 32'h22);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort");
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        run_dump(1'b0, 1'b0, 1'b0, dc, nb, fv, us);
        check("restart_done_cycle", 32'(dc), 32'(DONE_CYC));
        check("restart_byte_count", 32'(nb), 32'(NBYTES));
        check_bytes("restart");
        tick();

        // Simultaneous start and abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'h0);
        check("start_abort_port_sel", 32'(port_sel), 32'h0);
        tick();
        check("start_abort_busy2", 32'(busy), 32'h0);

        // Reset mid-SEND
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("pre_reset_valid", 32'(data_valid), 32'h1);
        check("pre_reset_port_sel", 32'(port_sel), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("mid_reset");
        tick();
        check_idle("mid_reset_hold");

        // Pipeline writes r7 while the walk is still below r7
        run_dump(1'b0, 1'b0, 1'b1, dc, nb, fv, us);
        check("write_done_cycle", 32'(dc), 32'(DONE_CYC));
        check("r7_b0", 32'(got[(7 - FIRST) * 4 + 0]), 32'hEF);
        check("r7_b1", 32'(got[(7 - FIRST) * 4 + 1]), 32'hBE);
        check("r7_b2", 32'(got[(7 - FIRST) * 4 + 2]), 32'hAD);
        check("r7_b3", 32'(got[(7 - FIRST) * 4 + 3]), 32'hDE);
        check("r6_b0_unchanged", 32'(got[(6 - FIRST) * 4]), 32'h06);
        check("r8_b0_unchanged", 32'(got[(8 - FIRST) * 4]), 32'h08);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/registers_dump_sequencer.md
Name: registers_dump_sequencer

Overview:
- Debug-side controller for the register bank.
- On request, it takes the bank's read port A away from the pipeline (via a mux select), walks every register address in order, and captures each word.
- It streams each word out as bytes over a valid/ready handshake to the debug UART transmitter.
- Used while the pipeline is halted to dump the architectural register state to the host.

Parameters:
- REGISTERS_BANK_SIZE, 32, number of registers in the bank; address width = $clog2(REGISTERS_BANK_SIZE).
- REGISTERS_SIZE, 32, register width in bits; must be a multiple of BYTE_SIZE.
- BYTE_SIZE, 8, width of the output stream symbol.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  dump request; sampled only in IDLE.
- i_abort  in  1  cancel the dump; returns to IDLE without o_done.
- i_reg_data  in  REGISTERS_SIZE  bank read-port-A data (combinational from o_addr).
- i_data_ready  in  1  downstream sink ready.
- o_addr  out  $clog2(REGISTERS_BANK_SIZE)  address driven onto bank port A while o_port_sel=1.
- o_port_sel  out  1  1 = sequencer owns port A; 0 = pipeline owns it.
- o_data  out  BYTE_SIZE  current output byte.
- o_data_valid  out  1  o_data valid.
- o_busy  out  1  high in any state except IDLE.
- o_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values: state=IDLE, o_addr=0, o_port_sel=0, o_data=0, o_data_valid=0, o_busy=0, o_done=0; byte counter=0; shift register=0.
- States: IDLE, LOAD, SEND, NEXT, DONE. BPR = REGISTERS_SIZE/BYTE_SIZE.
- IDLE:
  - i_start=1 -> LOAD; address counter = first address (0).
  - Otherwise stay.
- LOAD:
  - o_port_sel=1, o_addr=counter.
  - At the posedge, capture i_reg_data into the shift register; byte counter=0; -> SEND.
  - One cycle only.
- SEND:
  - o_data_valid=1; o_data = shift_reg[BYTE_SIZE-1:0]; little-endian, so byte 0 is bits [7:0].
  - A transfer occurs on a posedge with valid && ready. On transfer: shift right by BYTE_SIZE and increment the byte counter.
  - On the BPR-th transfer -> NEXT.
  - o_data and o_data_valid must stay stable while ready=0.
- NEXT:
  - If the counter equals REGISTERS_BANK_SIZE-1 -> DONE.
  - Else increment the counter -> LOAD.
  - o_data_valid=0 in this state.
- DONE: o_done=1 for exactly this one cycle; o_port_sel=0; -> IDLE.
- Latency:
  - i_start at edge N -> first valid byte at cycle N+2.
  - Gap of 2 bubble cycles (NEXT, LOAD) between registers.
  - With ready held high, the full default dump takes 1+32*(4+2)+1 = 194 cycles from start to o_done.
- o_port_sel: high in LOAD, SEND and NEXT; low in IDLE and DONE.
- o_addr: registered counter value in all states; returns to 0 in IDLE.
- i_start while busy: ignored.
- Simultaneous i_start and i_abort in IDLE: abort wins, stay IDLE.
- i_abort in any non-IDLE state: next cycle IDLE, with o_data_valid=0, o_port_sel=0 and no o_done. An in-flight handshake on that same edge is still counted as accepted by the sink.
- i_reset mid-dump: same as abort, and all outputs take their reset values.
- Register writes during a dump are not blocked. The captured value is whatever the bank holds at the LOAD posedge (writes land on negedge).

Optional Feature:
- Macro REGISTERS_DUMP_SKIP_ZERO_EN.
- Defined:
  - The first address is 1; register 0 (hard-wired zero) is never read or sent.
  - Default dump = 124 bytes; first o_addr in LOAD = 1.
- Undefined: the first address is 0; 128 bytes are sent.

Test Plan:
- Preload regs r[k]=32'h11223300+k; reset; pulse i_start; ready=1 -> first bytes 8'h00,8'h33,8'h22,8'h11 (r0=0 forced: 00,00,00,00 when zero-skip off). r1 bytes 01,33,22,11. o_done at cycle 194; 128 bytes total.
- Ready toggling 1-0-1 every cycle -> o_data stable during ready=0; no byte lost or duplicated; byte sequence identical to the ready=1 run.
- i_abort asserted during byte 2 of r5 -> next cycle o_busy=0, o_port_sel=0, o_data_valid=0; o_done never pulses; a new i_start restarts at r0 byte 0.
- i_reset asserted mid-SEND -> all outputs at reset values next cycle; i_start during busy (at r3) has no effect on the byte count.
- Pipeline write r7=32'hDEADBEEF during the dump while counter<7 -> dump shows EF,BE,AD,DE for r7.
- REGISTERS_DUMP_SKIP_ZERO_EN defined -> first LOAD o_addr=1; 124 bytes; o_done at cycle 1+31*6+1=188.
